// File: rtl/kamikaze_decode.sv
// rtl/kamikaze_decode.sv - RV32I decode stage with load-use bubble insertion
module kamikaze_decode (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        f_valid_i,
  input  logic [31:0] f_ir_i,
  input  logic [31:0] f_pc_i,
  input  logic        f_is_compressed_i,
  output logic        f_stall_o,
  input  logic        d_stall_i,
  input  logic        d_kill_i,
  output logic [4:0]  rf_rs1_o,
  output logic [4:0]  rf_rs2_o,
  output logic        d_valid_o,
  output logic [31:0] d_pc_o,
  output logic [31:0] d_link_pc_o,
  output logic [4:0]  d_opcode_o,
  output logic [2:0]  d_fun_o,
  output logic        d_fun7b5_o,
  output logic [4:0]  d_rs1_o,
  output logic [4:0]  d_rs2_o,
  output logic [4:0]  d_rd_o,
  output logic [31:0] d_imm_o,
  output logic        d_rd_write_o,
  output logic        d_is_load_o,
  output logic        d_is_store_o,
  output logic        d_is_branch_o,
  output logic        d_is_jal_o,
  output logic        d_is_jalr_o,
  output logic        d_is_system_o,
  output logic        d_illegal_o
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_MISC   = 5'b00011;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  logic [4:0]  opc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  fun3;
  logic        illegal;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        rd_write;
  logic [31:0] imm;
  logic        hazard;

  assign opc  = f_ir_i[6:2];
  assign rs1  = f_ir_i[19:15];
  assign rs2  = f_ir_i[24:20];
  assign rd   = f_ir_i[11:7];
  assign fun3 = f_ir_i[14:12];

  assign rf_rs1_o = rs1;
  assign rf_rs2_o = rs2;

  // Field decode of the incoming instruction: legality, operand use, immediate, rd write
  always_comb begin
    illegal  = 1'b0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    rd_write = 1'b0;
    imm      = 32'd0;
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        imm      = {{20{f_ir_i[31]}}, f_ir_i[31:20]};
        rd_write = 1'b1;
      end
      OPC_MISC:   imm = {{20{f_ir_i[31]}}, f_ir_i[31:20]};
      OPC_AUIPC, OPC_LUI: begin
        imm      = {f_ir_i[31:12], 12'd0};
        uses_rs1 = 1'b0;
        rd_write = 1'b1;
      end
      OPC_STORE: begin
        imm      = {{20{f_ir_i[31]}}, f_ir_i[31:25], f_ir_i[11:7]};
        uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        uses_rs2 = 1'b1;
        rd_write = 1'b1;
      end
      OPC_BRANCH: begin
        imm      = {{20{f_ir_i[31]}}, f_ir_i[7], f_ir_i[30:25], f_ir_i[11:8], 1'b0};
        uses_rs2 = 1'b1;
      end
      OPC_JAL: begin
        imm      = {{12{f_ir_i[31]}}, f_ir_i[19:12], f_ir_i[20], f_ir_i[30:21], 1'b0};
        uses_rs1 = 1'b0;
        rd_write = 1'b1;
      end
      OPC_SYSTEM: rd_write = (fun3 != 3'd0);
      default: begin
        illegal  = 1'b1;
        uses_rs1 = 1'b0;
      end
    endcase
    if (f_ir_i[1:0] != 2'b11) begin
      illegal  = 1'b1;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      rd_write = 1'b0;
    end
    if (illegal || rd == 5'd0) rd_write = 1'b0;
  end

  assign hazard = d_valid_o & d_is_load_o & (d_rd_o != 5'd0) & f_valid_i &
                  ((uses_rs1 & (rs1 == d_rd_o)) | (uses_rs2 & (rs2 == d_rd_o)));

  assign f_stall_o = d_stall_i | (hazard & ~d_kill_i);

  // Bundle register: reset, hold on execute stall, bubble on kill/hazard, else capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_valid_o     <= 1'b0;
      d_pc_o        <= 32'd0;
      d_link_pc_o   <= 32'd0;
      d_opcode_o    <= 5'd0;
      d_fun_o       <= 3'd0;
      d_fun7b5_o    <= 1'b0;
      d_rs1_o       <= 5'd0;
      d_rs2_o       <= 5'd0;
      d_rd_o        <= 5'd0;
      d_imm_o       <= 32'd0;
      d_rd_write_o  <= 1'b0;
      d_is_load_o   <= 1'b0;
      d_is_store_o  <= 1'b0;
      d_is_branch_o <= 1'b0;
      d_is_jal_o    <= 1'b0;
      d_is_jalr_o   <= 1'b0;
      d_is_system_o <= 1'b0;
      d_illegal_o   <= 1'b0;
    end else if (!d_stall_i) begin
      if (d_kill_i || hazard) begin
        d_valid_o <= 1'b0;
      end else begin
        d_valid_o     <= f_valid_i;
        d_pc_o        <= f_pc_i;
        d_link_pc_o   <= f_pc_i + (f_is_compressed_i ? 32'd2 : 32'd4);
        d_opcode_o    <= opc;
        d_fun_o       <= fun3;
        d_fun7b5_o    <= f_ir_i[30];
        d_rs1_o       <= rs1;
        d_rs2_o       <= rs2;
        d_rd_o        <= rd;
        d_imm_o       <= imm;
        d_rd_write_o  <= rd_write;
        d_is_load_o   <= !illegal && opc == OPC_LOAD;
        d_is_store_o  <= !illegal && opc == OPC_STORE;
        d_is_branch_o <= !illegal && opc == OPC_BRANCH;
        d_is_jal_o    <= !illegal && opc == OPC_JAL;
        d_is_jalr_o   <= !illegal && opc == OPC_JALR;
        d_is_system_o <= !illegal && opc == OPC_SYSTEM;
        d_illegal_o   <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_kamikaze_decode.sv
// tb/tb_kamikaze_decode.sv - directed self-checking bench for kamikaze_decode
module tb_kamikaze_decode;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        f_valid_i;
  logic [31:0] f_ir_i;
  logic [31:0] f_pc_i;
  logic        f_is_compressed_i;
  logic        f_stall_o;
  logic        d_stall_i;
  logic        d_kill_i;
  logic [4:0]  rf_rs1_o, rf_rs2_o;
  logic        d_valid_o;
  logic [31:0] d_pc_o, d_link_pc_o, d_imm_o;
  logic [4:0]  d_opcode_o, d_rs1_o, d_rs2_o, d_rd_o;
  logic [2:0]  d_fun_o;
  logic        d_fun7b5_o, d_rd_write_o, d_is_load_o, d_is_store_o, d_is_branch_o;
  logic        d_is_jal_o, d_is_jalr_o, d_is_system_o, d_illegal_o;

  int checks = 0;
  int errors = 0;

  kamikaze_decode dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .f_valid_i(f_valid_i), .f_ir_i(f_ir_i), .f_pc_i(f_pc_i),
    .f_is_compressed_i(f_is_compressed_i), .f_stall_o(f_stall_o),
    .d_stall_i(d_stall_i), .d_kill_i(d_kill_i),
    .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
    .d_valid_o(d_valid_o), .d_pc_o(d_pc_o), .d_link_pc_o(d_link_pc_o),
    .d_opcode_o(d_opcode_o), .d_fun_o(d_fun_o), .d_fun7b5_o(d_fun7b5_o),
    .d_rs1_o(d_rs1_o), .d_rs2_o(d_rs2_o), .d_rd_o(d_rd_o), .d_imm_o(d_imm_o),
    .d_rd_write_o(d_rd_write_o), .d_is_load_o(d_is_load_o),
    .d_is_store_o(d_is_store_o), .d_is_branch_o(d_is_branch_o),
    .d_is_jal_o(d_is_jal_o), .d_is_jalr_o(d_is_jalr_o),
    .d_is_system_o(d_is_system_o), .d_illegal_o(d_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc, input logic c);
    f_valid_i = v;
    f_ir_i = ir;
    f_pc_i = pc;
    f_is_compressed_i = c;
    #1;
  endtask

  initial begin
    rst_i = 1'b1; d_stall_i = 1'b0; d_kill_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    check("rst_valid", d_valid_o, 0);
    check("rst_pc", d_pc_o, 0);
    check("rst_imm", d_imm_o, 0);
    rst_i = 1'b0;

    // ADDI x1, x2, -5
    drive(1'b1, 32'hFFB10093, 32'h100, 1'b0);
    check("rf_rs1", rf_rs1_o, 2);
    tick();
    check("addi_valid", d_valid_o, 1);
    check("addi_rs1", d_rs1_o, 2);
    check("addi_rd", d_rd_o, 1);
    check("addi_imm", d_imm_o, 32'hFFFFFFFB);
    check("addi_opcode", d_opcode_o, 5'b00100);
    check("addi_rdw", d_rd_write_o, 1);
    check("addi_link", d_link_pc_o, 32'h104);
    check("addi_illegal", d_illegal_o, 0);

    // LW x5, 0(x1) then ADD x6, x5, x7
    drive(1'b1, 32'h0000A283, 32'h104, 1'b0);
    tick();
    check("lw_isload", d_is_load_o, 1);
    check("lw_rd", d_rd_o, 5);
    check("lw_fun", d_fun_o, 2);
    drive(1'b1, 32'h00728333, 32'h108, 1'b0);
    check("lu_stall", f_stall_o, 1);
    tick();
    check("lu_bubble", d_valid_o, 0);
    check("lu_stall_drop", f_stall_o, 0);
    tick();
    check("add_valid", d_valid_o, 1);
    check("add_rs1", d_rs1_o, 5);
    check("add_rs2", d_rs2_o, 7);
    check("add_rd", d_rd_o, 6);
    check("add_imm", d_imm_o, 0);
    check("add_isload", d_is_load_o, 0);

    // LW x0 then consumer: no hazard because rd is x0
    drive(1'b1, 32'h0000A003, 32'h10C, 1'b0);
    tick();
    check("lwx0_rdw", d_rd_write_o, 0);
    drive(1'b1, 32'h00028333, 32'h110, 1'b0);
    check("lwx0_nostall", f_stall_o, 0);
    tick();
    check("lwx0_issue", d_valid_o, 1);

    // Kill with a valid ADDI on the input
    d_kill_i = 1'b1;
    drive(1'b1, 32'hFFB10093, 32'h114, 1'b0);
    tick();
    d_kill_i = 1'b0;
    check("kill_valid", d_valid_o, 0);

    // Kill coincident with a load-use hazard
    drive(1'b1, 32'h0000A283, 32'h118, 1'b0);
    tick();
    drive(1'b1, 32'h00728333, 32'h11C, 1'b0);
    check("kh_stall_nokill", f_stall_o, 1);
    d_kill_i = 1'b1;
    #1;
    check("kh_stall_kill", f_stall_o, 0);
    tick();
    d_kill_i = 1'b0;
    check("kh_valid", d_valid_o, 0);

    // SW x7, -8(x5)
    drive(1'b1, 32'hFE72AC23, 32'h120, 1'b0);
    tick();
    check("sw_imm", d_imm_o, 32'hFFFFFFF8);
    check("sw_isstore", d_is_store_o, 1);
    check("sw_rdw", d_rd_write_o, 0);

    // Execute stall: hold ADDI for three cycles while the input changes
    drive(1'b1, 32'hFFB10093, 32'h300, 1'b0);
    tick();
    check("pre_stall_pc", d_pc_o, 32'h300);
    d_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000A283 + i, 32'h400 + 32'(i * 4), 1'b0);
      check("stall_fstall", f_stall_o, 1);
      tick();
      check("stall_valid", d_valid_o, 1);
      check("stall_pc", d_pc_o, 32'h300);
      check("stall_imm", d_imm_o, 32'hFFFFFFFB);
      check("stall_rd", d_rd_o, 1);
      check("stall_link", d_link_pc_o, 32'h304);
    end
    d_stall_i = 1'b0;

    // Compressed JAL x1, +8 captured after release
    drive(1'b1, 32'h008000EF, 32'h200, 1'b1);
    check("rel_fstall", f_stall_o, 0);
    tick();
    check("jal_pc", d_pc_o, 32'h200);
    check("jal_isjal", d_is_jal_o, 1);
    check("jal_imm", d_imm_o, 8);
    check("jal_link", d_link_pc_o, 32'h202);
    check("jal_rd", d_rd_o, 1);
    check("jal_rdw", d_rd_write_o, 1);

    // Link PC wraps at 2^32
    drive(1'b1, 32'hFFB10093, 32'hFFFFFFFC, 1'b0);
    tick();
    check("wrap_link", d_link_pc_o, 32'h0);

    // Illegal encoding
    drive(1'b1, 32'hFFFFFFFF, 32'h500, 1'b0);
    tick();
    check("ill_valid", d_valid_o, 1);
    check("ill_flag", d_illegal_o, 1);
    check("ill_rdw", d_rd_write_o, 0);
    check("ill_classes", {d_is_load_o, d_is_store_o, d_is_branch_o, d_is_jal_o,
                          d_is_jalr_o, d_is_system_o}, 0);

    // Reset while a bundle is held
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("mrst_valid", d_valid_o, 0);
    check("mrst_illegal", d_illegal_o, 0);
    check("mrst_pc", d_pc_o, 0);
    check("mrst_link", d_link_pc_o, 0);
    check("mrst_rd", d_rd_o, 0);
    check("mrst_opcode", d_opcode_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kamikaze_decode.md
Name: kamikaze_decode

Overview:
- Decode stage directly downstream of instruction fetch in the Kamikaze-uRV pipeline.
- Consumes each fetched, already-expanded 32-bit RV32I instruction with its PC and compressed flag.
- Produces a registered, field-decoded instruction bundle for execute, plus register-file read addresses.
- Detects load-use hazards and back-pressures fetch by inserting one bubble.

Parameters:
- none

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
f_valid_i  in  1  fetch output valid
f_ir_i  in  32  expanded instruction
f_pc_i  in  32  instruction PC
f_is_compressed_i  in  1  original encoding was 16-bit
f_stall_o  out  1  hold fetch (combinational)
d_stall_i  in  1  execute cannot accept; hold decode registers
d_kill_i  in  1  flush instruction entering decode (taken branch)
rf_rs1_o  out  5  regfile read address = f_ir_i[19:15] (combinational)
rf_rs2_o  out  5  regfile read address = f_ir_i[24:20] (combinational)
d_valid_o  out  1  bundle valid
d_pc_o  out  32  PC
d_link_pc_o  out  32  PC+2 if compressed, else PC+4
d_opcode_o  out  5  f_ir_i[6:2]
d_fun_o  out  3  funct3
d_fun7b5_o  out  1  f_ir_i[30]
d_rs1_o, d_rs2_o, d_rd_o  out  5 each  register indices
d_imm_o  out  32  sign-extended immediate
d_rd_write_o  out  1  writes rd (forced 0 when rd==0)
d_is_load_o, d_is_store_o, d_is_branch_o, d_is_jal_o, d_is_jalr_o, d_is_system_o  out  1 each  class flags
d_illegal_o  out  1  unsupported encoding

Behaviour:
- All d_* outputs and registers reset to 0 in the cycle rst_i is high. Reset mid-operation discards the held bundle.
- Latency: 1 cycle from f_* inputs to d_* outputs.
- Hazard, combinational:
  - hazard = d_valid_o & d_is_load_o & (d_rd_o!=0) & f_valid_i & ((uses_rs1 & rs1==d_rd_o) | (uses_rs2 & rs2==d_rd_o)).
  - uses_rs1: every class except LUI, AUIPC, JAL.
  - uses_rs2: BRANCH, STORE, OP.
- f_stall_o = d_stall_i | (hazard & !d_kill_i).
- Clock-edge priority:
  1. rst_i: clear all outputs and registers.
  2. d_stall_i: hold every register, including d_valid_o.
  3. d_kill_i: d_valid_o<=0. Other fields are don't-care.
  4. hazard: d_valid_o<=0 (bubble). The instruction is re-presented next cycle.
  5. Otherwise: capture the decoded bundle; d_valid_o<=f_valid_i.
- Simultaneous kill and hazard: kill wins and f_stall_o is 0.
- Immediates:
  - I: ir[31:20].
  - S: {ir[31:25],ir[11:7]}.
  - B: {ir[31],ir[7],ir[30:25],ir[11:8],0}.
  - U: {ir[31:12],12'b0}.
  - J: {ir[31],ir[19:12],ir[20],ir[30:21],0}.
  - All formats sign-extended from ir[31]. OP and SYSTEM produce imm 0.
- d_rd_write_o is set for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and SYSTEM with funct3!=0; it is then ANDed with rd!=0.
- d_illegal_o=1 when either:
  - ir[1:0]!=2'b11, or
  - opcode is not one of LOAD, MISC-MEM, OP-IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM.
- An illegal instruction still yields d_valid_o=1 (execute traps); it gets d_rd_write_o=0 and all class flags 0.
- d_link_pc_o arithmetic is 32-bit and wraps modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000).

Test Plan:
1. Decode ADDI: f_ir 0xFFB10093, pc 0x100, valid, uncompressed -> next cycle:
   - d_valid 1, d_rs1 2, d_rd 1, d_imm 0xFFFFFFFB, d_opcode 5'b00100, d_rd_write 1, d_link_pc 0x104.
2. Load-use: LW 0x0000A283 (rd 5), then ADD 0x00728333 (rs1 5) ->
   - f_stall_o high exactly one cycle, d_valid 0 that cycle.
   - Next cycle the ADD is issued with d_rs1 5, d_rs2 7, d_rd 6.
   - Control: with rd=x0 there is no stall.
3. Kill: d_kill_i with valid ADDI on the input -> d_valid 0 next cycle. Kill coincident with the load-use hazard -> f_stall_o 0.
4. Execute stall: d_stall_i high 3 cycles while the input changes -> d_* outputs held bit-identical and f_stall_o 1 throughout; the new instruction is captured the cycle after release.
5. Compressed JAL: f_ir 0x008000EF, pc 0x200, compressed -> d_is_jal 1, d_imm 8, d_link_pc 0x202, d_rd 1.
6. Illegal and reset:
   - f_ir 0xFFFFFFFF -> d_valid 1, d_illegal 1, d_rd_write 0.
   - Assert rst_i while d_valid=1 -> all outputs 0 after the next edge.
